// File: rtl/coherence_bus_ctrl_rr.sv
// rtl/coherence_bus_ctrl_rr.sv - round-robin snoopy MSI bus controller between private L1 caches and a shared L2
// Ports: CLK/RST; per-L1 request side dREN/dWEN/daddr/dstore/ccwrite and responder side
// ccsnoophit/ccsnoopdone/ccdirty/snoop_dstore; per-L1 outputs dwait/dload/ccwait/ccinv/ccexclusive;
// ccsnoopaddr broadcast; L2 beat port l2addr/l2store/l2REN/l2WEN/l2load/l2state.
// Optional macro BUS_CTRL_PERF_EN adds perf_txn/perf_c2c/perf_l2rd saturating counters.
module coherence_bus_ctrl_rr #(
  parameter int CPUS       = 2,
  parameter int BLOCK_SIZE = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CPUS-1:0]               dREN,
  input  logic [CPUS-1:0]               dWEN,
  input  logic [CPUS*32-1:0]            daddr,
  input  logic [CPUS*32*BLOCK_SIZE-1:0] dstore,
  input  logic [CPUS-1:0]               ccwrite,
  input  logic [CPUS-1:0]               ccsnoophit,
  input  logic [CPUS-1:0]               ccsnoopdone,
  input  logic [CPUS-1:0]               ccdirty,
  input  logic [CPUS*32*BLOCK_SIZE-1:0] snoop_dstore,
  output logic [CPUS-1:0]               dwait,
  output logic [CPUS*32*BLOCK_SIZE-1:0] dload,
  output logic [CPUS-1:0]               ccwait,
  output logic [CPUS-1:0]               ccinv,
  output logic [CPUS-1:0]               ccexclusive,
  output logic [31:0]                   ccsnoopaddr,
  output logic [31:0]                   l2addr,
  output logic [31:0]                   l2store,
  output logic                          l2REN,
  output logic                          l2WEN,
  input  logic [31:0]                   l2load,
  input  logic [1:0]                    l2state
`ifdef BUS_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_txn,
  output logic [31:0]                   perf_c2c,
  output logic [31:0]                   perf_l2rd
`endif
);

  localparam int DW  = 32 * BLOCK_SIZE;
  localparam int IDW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [1:0]    L2_ACCESS = 2'd2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SNOOP_R, S_SNOOP_RX, S_SNOOP_INV, S_TRANSFER,
    S_READ_L2, S_WRITEBACK, S_WRITEBACK_MS, S_DONE
  } state_t;
  typedef enum logic [1:0] {K_R, K_RX, K_INV, K_WB} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [IDW-1:0]  req_q, req_d, rr_q, rr_d, src_q, src_d;
  logic [31:0]     addr_q, addr_d;
  logic [DW-1:0]   line_q, line_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            hit_q, hit_d;

  logic [CPUS-1:0] request, others, hits;
  logic [IDW-1:0]  grant, src_first;
  logic            grant_vld, snoop_all_done;
  logic [31:0]     beat_addr;

  // An upgrade arrives as ccwrite alone, so it counts as a request too.
  assign request        = dREN | dWEN | ccwrite;
  assign others         = ~(CPUS'(1) << req_q);
  assign hits           = ccsnoophit & others;
  assign snoop_all_done = &(ccsnoopdone | ~others);
  assign beat_addr      = addr_q + {{(30-BW){1'b0}}, beat_q, 2'b00};

  // Scan downwards so the last hit written is the smallest offset from rr_q.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (request[(int'(rr_q) + i) % CPUS]) begin
        grant     = IDW'((int'(rr_q) + i) % CPUS);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    src_first = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (hits[i]) src_first = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    req_d   = req_q;
    rr_d    = rr_q;
    src_d   = src_q;
    addr_d  = addr_q;
    line_d  = line_q;
    beat_d  = beat_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_d  = grant;
          rr_d   = IDW'((int'(grant) + 1) % CPUS);
          addr_d = daddr[int'(grant)*32 +: 32];
          line_d = dstore[int'(grant)*DW +: DW];
          beat_d = '0;
          hit_d  = 1'b0;
          if (dWEN[grant]) begin
            state_d = S_WRITEBACK;
            kind_d  = K_WB;
          end else if (dREN[grant] && !ccwrite[grant]) begin
            state_d = S_SNOOP_R;
            kind_d  = K_R;
          end else if (dREN[grant]) begin
            state_d = S_SNOOP_RX;
            kind_d  = K_RX;
          end else begin
            state_d = S_SNOOP_INV;
            kind_d  = K_INV;
          end
        end
      end
      S_SNOOP_R, S_SNOOP_RX, S_SNOOP_INV: begin
        if (snoop_all_done) begin
          if (state_q == S_SNOOP_INV) begin
            state_d = S_DONE;
          end else if (|hits) begin
            src_d   = src_first;
            hit_d   = 1'b1;
            state_d = S_TRANSFER;
          end else begin
            state_d = S_READ_L2;
          end
        end
      end
      S_TRANSFER: begin
        line_d = snoop_dstore[int'(src_q)*DW +: DW];
        // A plain read leaves the responder in S, so its dirty copy must reach L2.
        if (kind_q == K_R && ccdirty[src_q]) state_d = S_WRITEBACK_MS;
        else                                 state_d = S_DONE;
      end
      S_READ_L2, S_WRITEBACK, S_WRITEBACK_MS: begin
        if (l2state == L2_ACCESS) begin
          if (state_q == S_READ_L2) line_d[int'(beat_q)*32 +: 32] = l2load;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccexclusive = '0;
    ccsnoopaddr = '0;
    l2addr      = '0;
    l2store     = '0;
    l2REN       = 1'b0;
    l2WEN       = 1'b0;
    case (state_q)
      S_SNOOP_R: begin
        ccwait      = others;
        ccsnoopaddr = addr_q;
      end
      S_SNOOP_RX, S_SNOOP_INV: begin
        ccwait      = others;
        ccinv       = others;
        ccsnoopaddr = addr_q;
      end
      S_READ_L2: begin
        l2REN  = 1'b1;
        l2addr = beat_addr;
      end
      S_WRITEBACK, S_WRITEBACK_MS: begin
        l2WEN   = 1'b1;
        l2addr  = beat_addr;
        l2store = line_q[int'(beat_q)*32 +: 32];
      end
      S_DONE: begin
        dwait[req_q]                  = 1'b0;
        dload[int'(req_q)*DW +: DW]   = line_q;
        if (kind_q == K_RX || kind_q == K_INV || (kind_q == K_R && !hit_q))
          ccexclusive[req_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      kind_q  <= K_R;
      req_q   <= '0;
      rr_q    <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      hit_q   <= hit_d;
    end
  end

`ifdef BUS_CTRL_PERF_EN
  logic [31:0] perf_txn_q, perf_c2c_q, perf_l2rd_q;

  // TRANSFER always lasts exactly one cycle, so each TRANSFER cycle is one entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_txn_q  <= '0;
      perf_c2c_q  <= '0;
      perf_l2rd_q <= '0;
    end else begin
      if (state_q == S_DONE && perf_txn_q != '1)
        perf_txn_q <= perf_txn_q + 32'd1;
      if (state_q == S_TRANSFER && perf_c2c_q != '1)
        perf_c2c_q <= perf_c2c_q + 32'd1;
      if (state_d == S_READ_L2 && state_q != S_READ_L2 && perf_l2rd_q != '1)
        perf_l2rd_q <= perf_l2rd_q + 32'd1;
    end
  end

  assign perf_txn  = perf_txn_q;
  assign perf_c2c  = perf_c2c_q;
  assign perf_l2rd = perf_l2rd_q;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl_rr.sv
// tb/tb_coherence_bus_ctrl_rr.sv - directed-vector bench for coherence_bus_ctrl_rr
module tb_coherence_bus_ctrl_rr;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   dREN, dWEN, ccwrite, ccsnoophit, ccsnoopdone, ccdirty;
  logic [63:0]  daddr;
  logic [127:0] dstore, snoop_dstore;
  logic [1:0]   dwait, ccwait, ccinv, ccexclusive;
  logic [127:0] dload;
  logic [31:0]  ccsnoopaddr, l2addr, l2store, l2load;
  logic         l2REN, l2WEN;
  logic [1:0]   l2state;
`ifdef BUS_CTRL_PERF_EN
  logic [31:0]  perf_txn, perf_c2c, perf_l2rd;
`endif

  coherence_bus_ctrl_rr #(.CPUS(2), .BLOCK_SIZE(2)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .ccsnoophit(ccsnoophit), .ccsnoopdone(ccsnoopdone), .ccdirty(ccdirty),
    .snoop_dstore(snoop_dstore), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccexclusive(ccexclusive), .ccsnoopaddr(ccsnoopaddr), .l2addr(l2addr), .l2store(l2store),
    .l2REN(l2REN), .l2WEN(l2WEN), .l2load(l2load), .l2state(l2state)
`ifdef BUS_CTRL_PERF_EN
    , .perf_txn(perf_txn), .perf_c2c(perf_c2c), .perf_l2rd(perf_l2rd)
`endif
  );

  always #5 CLK = ~CLK;

  // L2 model: answers every strobe at once unless an error is armed.
  logic [31:0] l2mem [0:1023];
  int          err_arm = 0;
  int          err_used = 0;
  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [63:0] wr_log[$];

  assign l2state = (l2REN | l2WEN) ? ((err_used < err_arm) ? 2'd3 : 2'd2) : 2'd0;
  assign l2load  = l2mem[l2addr[11:2]];

  always @(posedge CLK) begin
    if (!RST && (l2REN | l2WEN)) begin
      if (l2WEN) wa_log.push_back(l2addr);
      if (err_used < err_arm) begin
        err_used <= err_used + 1;
      end else begin
        if (l2REN) rd_log.push_back(l2addr);
        if (l2WEN) wr_log.push_back({l2addr, l2store});
      end
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [1:0]  seen_wait, seen_inv;
  int          inv_cnt;
  logic        seen_l2;
  logic [31:0] snoop_addr;

  task automatic clr_logs();
    rd_log.delete();
    wa_log.delete();
    wr_log.delete();
  endtask

  task automatic run_req(input int cpu, output int lat, output logic [63:0] line, output logic [1:0] excl);
    lat = 0; line = '0; excl = '0;
    seen_wait = '0; seen_inv = '0; inv_cnt = 0; seen_l2 = 1'b0; snoop_addr = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      seen_wait |= ccwait;
      seen_inv  |= ccinv;
      if (ccinv != 2'b00) inv_cnt++;
      if (l2REN | l2WEN) seen_l2 = 1'b1;
      if (ccwait != 2'b00) snoop_addr = ccsnoopaddr;
      if (dwait[cpu] == 1'b0) begin
        lat  = c + 1;
        line = dload[cpu*64 +: 64];
        excl = ccexclusive;
        break;
      end
    end
    if (lat == 0) chk("timeout", 64'd0, 64'd1);
    dREN = '0; dWEN = '0; ccwrite = '0;
    @(negedge CLK);
    chk("dwait_pulse_one_cycle", dwait, 2'b11);
  endtask

  int          lat;
  logic [63:0] line;
  logic [1:0]  excl;
  int          order[$];
  logic [63:0] lines[$];
  int          left [2];
  logic        got_first;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) l2mem[i] = '0;
    l2mem[32'h100 >> 2] = 32'hA;  l2mem[32'h104 >> 2] = 32'hB;
    l2mem[32'h600 >> 2] = 32'h60; l2mem[32'h604 >> 2] = 32'h64;
    l2mem[32'h700 >> 2] = 32'h70; l2mem[32'h704 >> 2] = 32'h74;
    l2mem[32'h800 >> 2] = 32'h80; l2mem[32'h804 >> 2] = 32'h84;
    RST = 1'b1; dREN = '0; dWEN = '0; ccwrite = '0; ccsnoophit = '0; ccsnoopdone = 2'b11;
    ccdirty = '0; daddr = '0; dstore = '0; snoop_dstore = '0;
    repeat (2) @(negedge CLK);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_dload", dload[63:0] | dload[127:64], 64'd0);
    chk("rst_cc", {ccwait, ccinv, ccexclusive}, 6'd0);
    chk("rst_l2", {l2REN, l2WEN, l2addr}, 34'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: read miss everywhere, line from L2
    clr_logs();
    daddr[31:0] = 32'h100; dREN = 2'b01;
    run_req(0, lat, line, excl);
    chk("t1_latency", lat, 5);
    chk("t1_dload", line, {32'hB, 32'hA});
    chk("t1_excl", excl, 2'b01);
    chk("t1_ccwait", seen_wait, 2'b10);
    chk("t1_rd_count", rd_log.size(), 2);
    if (rd_log.size() == 2) chk("t1_rd_addr", {rd_log[0], rd_log[1]}, {32'h100, 32'h104});

    // 2: read hits a dirty copy; line forwarded and written back
    clr_logs();
    daddr[63:32] = 32'h200; dREN = 2'b10; ccsnoophit = 2'b01; ccdirty = 2'b01;
    snoop_dstore[63:0] = {32'h2, 32'h1};
    run_req(1, lat, line, excl);
    ccsnoophit = '0; ccdirty = '0;
    chk("t2_latency", lat, 6);
    chk("t2_dload", line, {32'h2, 32'h1});
    chk("t2_excl", excl, 2'b00);
    chk("t2_rd_count", rd_log.size(), 0);
    chk("t2_wr_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t2_wr0", wr_log[0], {32'h200, 32'h1});
      chk("t2_wr1", wr_log[1], {32'h204, 32'h2});
    end

    // 2b: clean cache-to-cache transfer at minimum latency
    clr_logs();
    daddr[63:32] = 32'h500; dREN = 2'b10; ccsnoophit = 2'b01;
    snoop_dstore[63:0] = {32'h4, 32'h3};
    run_req(1, lat, line, excl);
    ccsnoophit = '0;
    chk("t2b_latency", lat, 4);
    chk("t2b_dload", line, {32'h4, 32'h3});
    chk("t2b_excl", excl, 2'b00);
    chk("t2b_no_l2", seen_l2, 1'b0);

    // 3: upgrade; responder answers late, requester's own done bit is ignored
    clr_logs();
    daddr[31:0] = 32'h300; ccwrite = 2'b01; ccsnoopdone = 2'b00;
    fork
      begin
        repeat (3) @(negedge CLK);
        ccsnoopdone = 2'b10;
      end
    join_none
    run_req(0, lat, line, excl);
    ccsnoopdone = 2'b11;
    chk("t3_inv_cycles", inv_cnt, 3);
    chk("t3_inv_target", seen_inv, 2'b10);
    chk("t3_snoop_addr", snoop_addr, 32'h300);
    chk("t3_no_l2", seen_l2, 1'b0);
    chk("t3_excl", excl, 2'b01);
    chk("t3_latency", lat, 5);

    // 5: eviction with one L2 error on the first beat
    clr_logs();
    daddr[63:32] = 32'h400; dWEN = 2'b10; dstore[127:64] = {32'h44, 32'h40};
    err_arm = err_used + 1;
    run_req(1, lat, line, excl);
    chk("t5_latency", lat, 5);
    chk("t5_attempts", wa_log.size(), 3);
    if (wa_log.size() == 3) chk("t5_attempt_addr", {wa_log[0], wa_log[1], wa_log[2]}, {32'h400, 32'h400, 32'h404});
    chk("t5_wr_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t5_wr0", wr_log[0], {32'h400, 32'h40});
      chk("t5_wr1", wr_log[1], {32'h404, 32'h44});
    end
    chk("t5_excl", excl, 2'b00);

    // 4: both CPUs request twice, requests held until served
    clr_logs();
    daddr = {32'h700, 32'h600}; dREN = 2'b11;
    left[0] = 2; left[1] = 2;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        if (dwait[k] == 1'b0) begin
          order.push_back(k);
          lines.push_back(dload[k*64 +: 64]);
          left[k]--;
          if (left[k] == 0) dREN[k] = 1'b0;
        end
      end
    end
    dREN = '0;
    chk("t4_grants", order.size(), 4);
    if (order.size() == 4) begin
      chk("t4_g0", order[0], 0);
      chk("t4_g1", order[1], 1);
      chk("t4_g2", order[2], 0);
      chk("t4_g3", order[3], 1);
      chk("t4_line1", lines[1], {32'h74, 32'h70});
      chk("t4_line2", lines[2], {32'h64, 32'h60});
    end
    @(negedge CLK);

    // 6: reset during the second L2 read beat
    daddr[31:0] = 32'h800; dREN = 2'b01;
    repeat (3) @(negedge CLK);
    chk("t6_in_beat1", {l2REN, l2addr}, {1'b1, 32'h804});
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_dwait", dwait, 2'b11);
    chk("t6_rst_l2ren", l2REN, 1'b0);
    chk("t6_rst_out", {ccwait, ccinv, ccexclusive, dload[63:0]}, 70'd0);
    RST = 1'b0;
    daddr[63:32] = 32'h700; dREN = 2'b11;
    got_first = 1'b0;
    for (int c = 1; c <= 50 && !got_first; c++) begin
      @(negedge CLK);
      if (dwait != 2'b11) begin
        got_first = 1'b1;
        chk("t6_first_grant", dwait, 2'b10);
        chk("t6_fresh_line", dload[63:0], {32'h84, 32'h80});
        chk("t6_latency", c + 1, 5);
      end
    end
    if (!got_first) chk("t6_timeout", 64'd0, 64'd1);
    dREN = '0;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
